// File: rtl/registers_mch.sv
// Multi-channel SDMAC register bank: NCH DMA channels behind one CPU register bus,
// each with control, sticky interrupt status, a word transfer counter and action strobes.
// Bus cycles are terminated through a small wait-state FSM; interrupts merge onto INT_O_.
module registers_mch #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned DW          = 32,
    parameter int unsigned WTC_W       = 24,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       ADDR,
    input  logic             DMAC_,
    input  logic             AS_,
    input  logic             RW,
    input  logic [DW-1:0]    MID,
    input  logic [NCH-1:0]   XFER,
    input  logic [NCH-1:0]   INTA_I,
    output logic [DW-1:0]    REG_OD,
    output logic             REG_DSK_,
    output logic             INT_O_,
    output logic [NCH-1:0]   DMAENA,
    output logic [NCH-1:0]   DMADIR,
    output logic [NCH-1:0]   FLUSHFIFO
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } bus_state_e;

    localparam logic [1:0] IdxCntr   = 2'd0;
    localparam logic [1:0] IdxIstr   = 2'd1;
    localparam logic [1:0] IdxWtc    = 2'd2;
    localparam logic [1:0] IdxStrobe = 2'd3;

    localparam logic [WTC_W-1:0] WtcZero = '0;
    localparam logic [WTC_W-1:0] WtcOne  = WTC_W'(1);

    // Bus FSM state
    bus_state_e state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;

    // Address decode
    logic [2:0]     sel_ch;
    logic [1:0]     sel_idx;
    logic [NCH-1:0] ch_hit;
    logic           cycle_start;
    logic           commit_wr;
    logic           commit_rd;

    // Per-channel write enables for the decoded register
    logic [NCH-1:0] wr_cntr;
    logic [NCH-1:0] wr_istr;
    logic [NCH-1:0] wr_wtc;
    logic [NCH-1:0] wr_strobe;

    // Channel state
    logic [NCH-1:0]            intena_q, intena_d;
    logic [NCH-1:0]            dmadir_q, dmadir_d;
    logic [NCH-1:0]            dmaena_q, dmaena_d;
    logic [NCH-1:0]            tc_q, tc_d;
    logic [NCH-1:0]            ext_q, ext_d;
    logic [NCH-1:0]            flush_q, flush_d;
    logic [NCH-1:0][WTC_W-1:0] wtc_q, wtc_d;

    logic [NCH-1:0] xfer_dec;
    logic [NCH-1:0] terminal;
    logic [NCH-1:0] pend;

    logic [DW-1:0] rd_data;
    logic [DW-1:0] reg_od_q;
    logic          int_n_q;

    // Address bits [1:0] are byte lanes and not decoded; high MID bits may be unused.
    logic unused_bits;
    assign unused_bits = ^{ADDR[1:0], MID};

    assign sel_ch      = ADDR[6:4];
    assign sel_idx     = ADDR[3:2];
    assign cycle_start = (state_q == StIdle) && !AS_ && !DMAC_;
    assign commit_wr   = cycle_start && !RW;
    assign commit_rd   = cycle_start && RW;

    // Channel hit and per-register write enables; unmapped accesses hit nothing
    always_comb begin
        ch_hit    = '0;
        wr_cntr   = '0;
        wr_istr   = '0;
        wr_wtc    = '0;
        wr_strobe = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_hit[i]    = !ADDR[7] && (sel_ch == 3'(i));
            wr_cntr[i]   = commit_wr && ch_hit[i] && (sel_idx == IdxCntr);
            wr_istr[i]   = commit_wr && ch_hit[i] && (sel_idx == IdxIstr);
            wr_wtc[i]    = commit_wr && ch_hit[i] && (sel_idx == IdxWtc);
            wr_strobe[i] = commit_wr && ch_hit[i] && (sel_idx == IdxStrobe);
        end
    end

    // Bus FSM next state: decode, count wait states, hold ACK until AS_ rises
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cycle_start) begin
                    state_d    = StWait;
                    wait_cnt_d = 3'(WAIT_STATES);
                end
            end
            StWait: begin
                if (AS_) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == 3'd0) begin
                    state_d = StAck;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            StAck: begin
                if (AS_) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Counter decrement qualifiers; a same-edge CPU write to WTC suppresses the decrement
    always_comb begin
        xfer_dec = '0;
        terminal = '0;
        for (int i = 0; i < NCH; i++) begin
            xfer_dec[i] = XFER[i] && dmaena_q[i] && (wtc_q[i] != WtcZero) && !wr_wtc[i];
            terminal[i] = xfer_dec[i] && (wtc_q[i] == WtcOne);
        end
    end

    // Channel next-state: CPU writes, strobes, counter and sticky status
    always_comb begin
        intena_d = intena_q;
        dmadir_d = dmadir_q;
        dmaena_d = dmaena_q;
        tc_d     = tc_q;
        ext_d    = ext_q;
        wtc_d    = wtc_q;
        flush_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_cntr[i]) begin
                intena_d[i] = MID[0];
                dmadir_d[i] = MID[1];
            end

            if (wr_wtc[i]) begin
                wtc_d[i] = MID[WTC_W-1:0];
            end else if (xfer_dec[i]) begin
                wtc_d[i] = wtc_q[i] - WtcOne;
            end

            // Terminal count stops the channel; a same-edge SP still forces it off
            if (terminal[i]) begin
                dmaena_d[i] = 1'b0;
            end
            if (wr_strobe[i] && MID[0]) begin
                dmaena_d[i] = 1'b1;
            end
            if (wr_strobe[i] && MID[1]) begin
                dmaena_d[i] = 1'b0;
            end
            flush_d[i] = wr_strobe[i] && MID[2];

            // Sticky status: a new event beats a simultaneous write-1-to-clear
            if (wr_istr[i] && MID[0]) begin
                tc_d[i] = 1'b0;
            end
            if (terminal[i]) begin
                tc_d[i] = 1'b1;
            end
            if (wr_istr[i] && MID[1]) begin
                ext_d[i] = 1'b0;
            end
            if (INTA_I[i]) begin
                ext_d[i] = 1'b1;
            end
        end
    end

    // Channel state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            intena_q <= '0;
            dmadir_q <= '0;
            dmaena_q <= '0;
            tc_q     <= '0;
            ext_q    <= '0;
            flush_q  <= '0;
            wtc_q    <= '0;
        end else begin
            intena_q <= intena_d;
            dmadir_q <= dmadir_d;
            dmaena_q <= dmaena_d;
            tc_q     <= tc_d;
            ext_q    <= ext_d;
            flush_q  <= flush_d;
            wtc_q    <= wtc_d;
        end
    end

    assign pend = (tc_q | ext_q) & intena_q;

    // Read mux for the addressed register; unmapped channels and STROBE read 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_hit[i]) begin
                unique case (sel_idx)
                    IdxCntr: rd_data = DW'({dmaena_q[i], 1'b0, dmadir_q[i], intena_q[i]});
                    IdxIstr: rd_data = DW'({pend[i], ext_q[i], tc_q[i]});
                    IdxWtc:  rd_data = DW'(wtc_q[i]);
                    default: rd_data = '0;
                endcase
            end
        end
    end

    // Read data captured at decode, held through ACK, cleared whenever the bus goes idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_od_q <= '0;
        end else if (cycle_start) begin
            reg_od_q <= commit_rd ? rd_data : '0;
        end else if (state_d == StIdle) begin
            reg_od_q <= '0;
        end
    end

    // Merged interrupt, registered one cycle behind the pending bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            int_n_q <= 1'b1;
        end else begin
            int_n_q <= ~(|pend);
        end
    end

    assign REG_OD    = reg_od_q;
    assign REG_DSK_  = (state_q != StAck);
    assign INT_O_    = int_n_q;
    assign DMAENA    = dmaena_q;
    assign DMADIR    = dmadir_q;
    assign FLUSHFIFO = flush_q;

endmodule

// File: doc/registers_mch.md
Name: registers_mch

Overview:
- Parametrised multi-channel successor to the single-channel SDMAC register bank.
- Provides NCH independent DMA channels on the existing CPU register bus (ADDR/DMAC_/AS_/RW/MID).
- Each channel has a control register, a sticky interrupt status register, a loadable word transfer counter (WTC) with terminal-count interrupt, and action strobes.
- Generates the register-cycle termination with programmable wait states and a single merged INT_O_.

Parameters:
- NCH, 4, channel count (1..8).
- DW, 32, data bus width for MID/REG_OD (16..32).
- WTC_W, 24, transfer counter width (8..DW).
- WAIT_STATES, 2, CLK cycles from cycle decode to REG_DSK_ assertion (0..7).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  reset, synchronous, active-high.
- ADDR  input  8  CPU address; ADDR[6:4] = channel, ADDR[3:2] = register index, ADDR[7] must be 0.
- DMAC_  input  1  SDMAC chip select, active low.
- AS_  input  1  CPU address strobe, active low.
- RW  input  1  1 = read, 0 = write.
- MID  input  DW  write data.
- XFER  input  NCH  per-channel one-cycle pulse: one word moved.
- INTA_I  input  NCH  per-channel external interrupt request, level.
- REG_OD  output  DW  read data.
- REG_DSK_  output  1  register cycle termination, active low.
- INT_O_  output  1  merged interrupt, active low.
- DMAENA  output  NCH  per-channel DMA enabled.
- DMADIR  output  NCH  per-channel direction; 1 = memory to peripheral.
- FLUSHFIFO  output  NCH  per-channel one-cycle flush pulse.

Behaviour:
- Reset: all registers 0; REG_DSK_=1, INT_O_=1, DMAENA=0, DMADIR=0, FLUSHFIFO=0, REG_OD=0, FSM in IDLE. RST mid-cycle aborts the cycle and forces IDLE and all reset values on the next edge.
- Register map per channel:
  - idx0 CNTR: RW bits {bit0 INTENA, bit1 DMADIR}; bit3 reads DMAENA (read-only).
  - idx1 ISTR: bit0 TC, bit1 EXT, bit2 PEND (read-only). Write-1-to-clear on bits 0-1.
  - idx2 WTC: RW, WTC_W bits, zero-extended to DW on read.
  - idx3 STROBE: write-only; bit0 ST_DMA, bit1 SP_DMA, bit2 FLUSH; reads 0.
- Unmapped access (channel >= NCH or ADDR[7]=1): acknowledged normally; reads 0; writes ignored.
- Bus FSM:
  - IDLE -> WAIT when AS_=0 and DMAC_=0; loads wait counter with WAIT_STATES.
  - WAIT decrements the counter and moves to ACK when it is 0. With WAIT_STATES=0, WAIT lasts one cycle.
  - ACK drives REG_DSK_=0 and holds until AS_=1, then returns to IDLE.
  - A cycle in which AS_ rises during WAIT returns to IDLE with no ACK.
- Write commit: exactly once per bus cycle, on the IDLE->WAIT edge, using ADDR/MID sampled then.
- Read data: REG_OD is registered on the IDLE->WAIT edge and held through ACK; it is 0 in IDLE.
- ST_DMA sets DMAENA. SP_DMA clears it. Both bits set in one write: SP wins, DMAENA=0.
- FLUSH: FLUSHFIFO[ch]=1 for exactly one cycle following the commit.
- WTC:
  - An XFER[ch] pulse with DMAENA=1 and WTC!=0 decrements WTC.
  - A decrement from 1 to 0 sets TC and clears DMAENA on the same edge.
  - XFER with WTC=0 or DMAENA=0 is ignored; the counter never wraps.
  - CPU write to WTC on the same edge as XFER: the write wins.
- EXT: set on any cycle INTA_I[ch]=1 (sticky). Set coincident with W1C clear: set wins.
- PEND = (TC|EXT) & INTENA.
- INT_O_ = ~OR(PEND over all channels), registered, so it appears one cycle after the PEND change.

Test Plan:
- Reset then read every register of ch0..NCH-1 -> all read 0. REG_DSK_ asserts exactly WAIT_STATES+1 cycles after AS_/DMAC_ fall and releases the cycle after AS_ rises.
- ch2: write WTC=3, CNTR=0x1, STROBE=0x1, then 3 XFER pulses -> WTC 3,2,1,0. On the 3rd: DMAENA[2]=0, ISTR[2]=0x5, INT_O_ low one cycle later. Write ISTR=0x1 -> ISTR=0, INT_O_=1.
- ch1: write STROBE=0x3 -> DMAENA[1] stays 0. Write STROBE=0x4 -> FLUSHFIFO[1]=1 for exactly one cycle; FLUSHFIFO for other channels never set.
- ch0: WTC=5, DMAENA=1; CPU write WTC=9 on the same edge as XFER[0] -> WTC=9. XFER with DMAENA=0 -> WTC unchanged.
- INTA_I[3] held high while writing ISTR=0x2 to ch3 -> EXT stays 1. With INTENA=0, INT_O_ stays 1.
- Read ADDR=0x80 and channel NCH -> acknowledged, REG_OD=0. RST asserted during WAIT -> REG_DSK_ stays 1 and the FSM is in IDLE the next cycle.
